axi_mm_arbiter_2to1: RTL and testbench
======================================

# axi_mm_arbiter_2to1

Two-master AXI4 memory-mapped arbiter placed between the PCIe XDMA AXI master (port 0), a local user AXI master (port 1) and the single AXI BRAM slave. Write path (AW/W/B) and read path (AR/R) are arbitrated independently with per-path round-robin grant. Each path holds its grant for one complete burst, then re-arbitrates.

## Interface
- AXI_IDWIDTH, 4, ID width on all ports; IDs pass through unchanged
- AXI_AWIDTH, 64, address width
- AXI_DWIDTH, 64, data width; strobe width AXI_DWIDTH/8
- clk  in  1  single clock for all ports (XDMA axi_aclk)
- rst  in  1  asynchronous, active-high reset
- sN_axi_awvalid/awready/awaddr/awlen/awid  (N=0,1)  AW slave side; valid in, ready out; len 8 bits
- sN_axi_wvalid/wready/wlast/wdata/wstrb  W slave side
- sN_axi_bvalid/bready/bid/bresp  B slave side; valid out, ready in; resp 2 bits
- sN_axi_arvalid/arready/araddr/arlen/arid  AR slave side
- sN_axi_rvalid/rready/rlast/rdata/rid/rresp  R slave side
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  master side toward BRAM, same signal set, opposite directions

## Operation
- Write FSM: WR_IDLE, WR_ADDR, WR_DATA, WR_RESP.
  - WR_IDLE: if any sN_axi_awvalid, latch winner into wr_gnt, go WR_ADDR.
  - WR_ADDR: forward granted AW; on m_axi_awvalid&&m_axi_awready go WR_DATA.
  - WR_DATA: forward granted W; on handshake with wlast go WR_RESP.
  - WR_RESP: forward B to granted port; on bvalid&&bready set wr_last=wr_gnt, go WR_IDLE.
- Read FSM: RD_IDLE, RD_ADDR, RD_DATA.
  - Same grant rule on arvalid.
  - RD_ADDR ends on AR handshake.
  - RD_DATA forwards R to granted port; ends on rvalid&&rready&&rlast, sets rd_last.
- Round-robin per path: if only one port requests, it wins. If both request, the port != last_gnt wins. last_gnt resets to 1, so port 0 wins the first tie.
- Forwarding: combinational mux/demux selected by the registered grant, active only in the matching state.
- Outside the active state:
  - m-side valids are 0.
  - Non-granted sN ready/valid outputs are 0.
  - Payload outputs may carry don't-care data.
- Both paths are fully concurrent. A write by port 0 and a read by port 1 proceed simultaneously.
- No ID remapping. Responses route by stored grant, not by ID.
- W data accepted before AW grant is not supported: sN_axi_wready stays 0 until WR_DATA with grant N.

## Timing
- Reset values: all m_axi_*valid, sN_axi_*ready, sN_axi_bvalid, sN_axi_rvalid = 0; FSMs in IDLE; wr_last=rd_last=1.
- Arbitration latency: awvalid/arvalid seen in IDLE at cycle T gives m-side valid at T+1. The sN ready rises combinationally with the m-side ready from T+1.
- After the burst-ending handshake at cycle T, the FSM is in IDLE at T+1 and the next grant is visible at T+2. There is one dead cycle per burst.
- The requester must hold valid and payload stable until its handshake (AXI rule). The arbiter never drops a granted valid.
- Simultaneous requests in IDLE are resolved by the round-robin rule. A request arriving mid-burst waits until IDLE.
- awlen/arlen = 0 (single beat): wlast/rlast is on the first beat, and the FSM leaves DATA after one handshake.
- Reset mid-burst: FSMs return immediately to IDLE and all valids/readies drop. Attached masters/slaves share rst, so no partial-burst recovery is needed.

## Structure
- Package axi_arb_pkg holds:
  - the wr_state_t and rd_state_t enums;
  - default width localparams (ID 4, A 64, D 64, LEN 8, RESP 2).
- Sub-module axi_arb_rr2: 2-request round-robin picker.
  - Inputs: req[1:0], last_gnt.
  - Output: gnt, combinational.
  - Instantiated once for the write path and once for the read path.
- Target size: about 250 lines of RTL.

## Test plan
- Port 0 writes awlen=3 at addr 0x100 (data 0xA0..0xA3), port 1 idle → four beats reach BRAM; s0 bvalid with bresp=0, bid echoed; read back returns 0xA0..0xA3.
- Both ports assert awvalid in the same cycle after reset → port 0 granted first, port 1 second; a third simultaneous pair is granted port 0 then port 1 again (alternation).
- Port 1 issues a read of awlen=7 while port 0 writes → both complete concurrently; cycle counts show no serialization between paths.
- Single-beat bursts (len=0) back-to-back from one port → each takes exactly one dead cycle between bursts; wlast and rlast are handled on the first beat.
- m_axi_rready backpressure: s1_axi_rready toggles every cycle during an 8-beat read → no beat lost or duplicated; s0 sees rvalid=0 throughout.
- rst asserted during WR_DATA beat 2 of 4 → the next cycle all valids/readies are 0 and the FSM is in IDLE; a new port 1 write after rst deassert completes normally.

Source files
------------

// File: rtl/axi_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_arb_pkg                                                                |
// | Shared widths and FSM state types for the 2:1 AXI4 memory-mapped arbiter.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package axi_arb_pkg;

  localparam int c_id_width   = 4;
  localparam int c_addr_width = 64;
  localparam int c_data_width = 64;
  localparam int c_len_width  = 8;
  localparam int c_resp_width = 2;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_arb_rr2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_arb_rr2                                                                |
// | Two-requester round-robin picker; gnt is the index of the winning request. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axi_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt
);

  // On a tie the port that did not win last time gets the path.
  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_gnt;
      default: gnt = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_mm_arbiter_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_mm_arbiter_2to1                                                        |
// | 2:1 AXI4 arbiter, independent burst-granular round-robin on write and read.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axi_mm_arbiter_2to1
  import axi_arb_pkg::*;
#(
  parameter int AXI_IDWIDTH = c_id_width,
  parameter int AXI_AWIDTH  = c_addr_width,
  parameter int AXI_DWIDTH  = c_data_width
) (
  input  logic                      clk,
  input  logic                      rst,
  // port 0 (XDMA)
  input  logic                      s0_axi_awvalid,
  output logic                      s0_axi_awready,
  input  logic [AXI_AWIDTH-1:0]     s0_axi_awaddr,
  input  logic [c_len_width-1:0]    s0_axi_awlen,
  input  logic [AXI_IDWIDTH-1:0]    s0_axi_awid,
  input  logic                      s0_axi_wvalid,
  output logic                      s0_axi_wready,
  input  logic                      s0_axi_wlast,
  input  logic [AXI_DWIDTH-1:0]     s0_axi_wdata,
  input  logic [AXI_DWIDTH/8-1:0]   s0_axi_wstrb,
  output logic                      s0_axi_bvalid,
  input  logic                      s0_axi_bready,
  output logic [AXI_IDWIDTH-1:0]    s0_axi_bid,
  output logic [c_resp_width-1:0]   s0_axi_bresp,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  input  logic [AXI_AWIDTH-1:0]     s0_axi_araddr,
  input  logic [c_len_width-1:0]    s0_axi_arlen,
  input  logic [AXI_IDWIDTH-1:0]    s0_axi_arid,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,
  output logic                      s0_axi_rlast,
  output logic [AXI_DWIDTH-1:0]     s0_axi_rdata,
  output logic [AXI_IDWIDTH-1:0]    s0_axi_rid,
  output logic [c_resp_width-1:0]   s0_axi_rresp,
  // port 1 (local user master)
  input  logic                      s1_axi_awvalid,
  output logic                      s1_axi_awready,
  input  logic [AXI_AWIDTH-1:0]     s1_axi_awaddr,
  input  logic [c_len_width-1:0]    s1_axi_awlen,
  input  logic [AXI_IDWIDTH-1:0]    s1_axi_awid,
  input  logic                      s1_axi_wvalid,
  output logic                      s1_axi_wready,
  input  logic                      s1_axi_wlast,
  input  logic [AXI_DWIDTH-1:0]     s1_axi_wdata,
  input  logic [AXI_DWIDTH/8-1:0]   s1_axi_wstrb,
  output logic                      s1_axi_bvalid,
  input  logic                      s1_axi_bready,
  output logic [AXI_IDWIDTH-1:0]    s1_axi_bid,
  output logic [c_resp_width-1:0]   s1_axi_bresp,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  input  logic [AXI_AWIDTH-1:0]     s1_axi_araddr,
  input  logic [c_len_width-1:0]    s1_axi_arlen,
  input  logic [AXI_IDWIDTH-1:0]    s1_axi_arid,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,
  output logic                      s1_axi_rlast,
  output logic [AXI_DWIDTH-1:0]     s1_axi_rdata,
  output logic [AXI_IDWIDTH-1:0]    s1_axi_rid,
  output logic [c_resp_width-1:0]   s1_axi_rresp,
  // master side toward BRAM
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_AWIDTH-1:0]     m_axi_awaddr,
  output logic [c_len_width-1:0]    m_axi_awlen,
  output logic [AXI_IDWIDTH-1:0]    m_axi_awid,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic                      m_axi_wlast,
  output logic [AXI_DWIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DWIDTH/8-1:0]   m_axi_wstrb,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [AXI_IDWIDTH-1:0]    m_axi_bid,
  input  logic [c_resp_width-1:0]   m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [AXI_AWIDTH-1:0]     m_axi_araddr,
  output logic [c_len_width-1:0]    m_axi_arlen,
  output logic [AXI_IDWIDTH-1:0]    m_axi_arid,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic                      m_axi_rlast,
  input  logic [AXI_DWIDTH-1:0]     m_axi_rdata,
  input  logic [AXI_IDWIDTH-1:0]    m_axi_rid,
  input  logic [c_resp_width-1:0]   m_axi_rresp
);

  wr_state_t r_wr_state, w_wr_state_nxt;
  rd_state_t r_rd_state, w_rd_state_nxt;
  logic      r_wr_gnt, w_wr_gnt_nxt, r_wr_last, w_wr_last_nxt;
  logic      r_rd_gnt, w_rd_gnt_nxt, r_rd_last, w_rd_last_nxt;
  logic      w_wr_pick, w_rd_pick;
  logic      w_aw_ph, w_w_ph, w_b_ph, w_ar_ph, w_r_ph;

  axi_arb_rr2 u_wr_rr (
    .req      ({s1_axi_awvalid, s0_axi_awvalid}),
    .last_gnt (r_wr_last),
    .gnt      (w_wr_pick)
  );

  axi_arb_rr2 u_rd_rr (
    .req      ({s1_axi_arvalid, s0_axi_arvalid}),
    .last_gnt (r_rd_last),
    .gnt      (w_rd_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= WR_IDLE;
      r_wr_gnt   <= 1'b0;
      r_wr_last  <= 1'b1;
      r_rd_state <= RD_IDLE;
      r_rd_gnt   <= 1'b0;
      r_rd_last  <= 1'b1;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_gnt   <= w_wr_gnt_nxt;
      r_wr_last  <= w_wr_last_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_rd_gnt   <= w_rd_gnt_nxt;
      r_rd_last  <= w_rd_last_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_gnt_nxt   = r_wr_gnt;
    w_wr_last_nxt  = r_wr_last;
    case (r_wr_state)
      WR_IDLE: if (s0_axi_awvalid || s1_axi_awvalid) begin
        w_wr_gnt_nxt   = w_wr_pick;
        w_wr_state_nxt = WR_ADDR;
      end
      WR_ADDR: if (m_axi_awvalid && m_axi_awready) w_wr_state_nxt = WR_DATA;
      WR_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) w_wr_state_nxt = WR_RESP;
      WR_RESP: if (m_axi_bvalid && m_axi_bready) begin
        w_wr_last_nxt  = r_wr_gnt;
        w_wr_state_nxt = WR_IDLE;
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_gnt_nxt   = r_rd_gnt;
    w_rd_last_nxt  = r_rd_last;
    case (r_rd_state)
      RD_IDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
        w_rd_gnt_nxt   = w_rd_pick;
        w_rd_state_nxt = RD_ADDR;
      end
      RD_ADDR: if (m_axi_arvalid && m_axi_arready) w_rd_state_nxt = RD_DATA;
      RD_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
        w_rd_last_nxt  = r_rd_gnt;
        w_rd_state_nxt = RD_IDLE;
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  assign w_aw_ph = (r_wr_state == WR_ADDR);
  assign w_w_ph  = (r_wr_state == WR_DATA);
  assign w_b_ph  = (r_wr_state == WR_RESP);
  assign w_ar_ph = (r_rd_state == RD_ADDR);
  assign w_r_ph  = (r_rd_state == RD_DATA);

  // Write path: handshakes gated by phase and grant; payloads are plain muxes.
  assign m_axi_awvalid  = w_aw_ph & (r_wr_gnt ? s1_axi_awvalid : s0_axi_awvalid);
  assign m_axi_awaddr   = r_wr_gnt ? s1_axi_awaddr : s0_axi_awaddr;
  assign m_axi_awlen    = r_wr_gnt ? s1_axi_awlen  : s0_axi_awlen;
  assign m_axi_awid     = r_wr_gnt ? s1_axi_awid   : s0_axi_awid;
  assign s0_axi_awready = w_aw_ph & ~r_wr_gnt & m_axi_awready;
  assign s1_axi_awready = w_aw_ph &  r_wr_gnt & m_axi_awready;

  assign m_axi_wvalid   = w_w_ph & (r_wr_gnt ? s1_axi_wvalid : s0_axi_wvalid);
  assign m_axi_wlast    = r_wr_gnt ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wdata    = r_wr_gnt ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb    = r_wr_gnt ? s1_axi_wstrb : s0_axi_wstrb;
  assign s0_axi_wready  = w_w_ph & ~r_wr_gnt & m_axi_wready;
  assign s1_axi_wready  = w_w_ph &  r_wr_gnt & m_axi_wready;

  assign m_axi_bready   = w_b_ph & (r_wr_gnt ? s1_axi_bready : s0_axi_bready);
  assign s0_axi_bvalid  = w_b_ph & ~r_wr_gnt & m_axi_bvalid;
  assign s1_axi_bvalid  = w_b_ph &  r_wr_gnt & m_axi_bvalid;
  assign s0_axi_bid     = m_axi_bid;
  assign s1_axi_bid     = m_axi_bid;
  assign s0_axi_bresp   = m_axi_bresp;
  assign s1_axi_bresp   = m_axi_bresp;

  // Read path: responses are steered by the stored grant, never by RID.
  assign m_axi_arvalid  = w_ar_ph & (r_rd_gnt ? s1_axi_arvalid : s0_axi_arvalid);
  assign m_axi_araddr   = r_rd_gnt ? s1_axi_araddr : s0_axi_araddr;
  assign m_axi_arlen    = r_rd_gnt ? s1_axi_arlen  : s0_axi_arlen;
  assign m_axi_arid     = r_rd_gnt ? s1_axi_arid   : s0_axi_arid;
  assign s0_axi_arready = w_ar_ph & ~r_rd_gnt & m_axi_arready;
  assign s1_axi_arready = w_ar_ph &  r_rd_gnt & m_axi_arready;

  assign m_axi_rready   = w_r_ph & (r_rd_gnt ? s1_axi_rready : s0_axi_rready);
  assign s0_axi_rvalid  = w_r_ph & ~r_rd_gnt & m_axi_rvalid;
  assign s1_axi_rvalid  = w_r_ph &  r_rd_gnt & m_axi_rvalid;
  assign s0_axi_rlast   = m_axi_rlast;
  assign s1_axi_rlast   = m_axi_rlast;
  assign s0_axi_rdata   = m_axi_rdata;
  assign s1_axi_rdata   = m_axi_rdata;
  assign s0_axi_rid     = m_axi_rid;
  assign s1_axi_rid     = m_axi_rid;
  assign s0_axi_rresp   = m_axi_rresp;
  assign s1_axi_rresp   = m_axi_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_mm_arbiter_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_mm_arbiter_2to1                                                     |
// | Directed bench: two AXI masters, a behavioural BRAM slave, timing monitor. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_axi_mm_arbiter_2to1;

  localparam int LIM = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
  logic [1:0][63:0]  s_awaddr, s_wdata, s_araddr;
  logic [1:0][7:0]   s_awlen, s_arlen, s_wstrb;
  logic [1:0][3:0]   s_awid, s_arid;
  logic [1:0]        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [1:0][3:0]   s_bid, s_rid;
  logic [1:0][1:0]   s_bresp, s_rresp;
  logic [1:0][63:0]  s_rdata;

  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [7:0]  m_awlen, m_arlen, m_wstrb;
  logic [3:0]  m_awid, m_bid, m_arid, m_rid;
  logic [1:0]  m_bresp, m_rresp;

  axi_mm_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]), .s0_axi_awaddr(s_awaddr[0]),
    .s0_axi_awlen(s_awlen[0]), .s0_axi_awid(s_awid[0]),
    .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]), .s0_axi_wlast(s_wlast[0]),
    .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]),
    .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]), .s0_axi_bid(s_bid[0]), .s0_axi_bresp(s_bresp[0]),
    .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s_arready[0]), .s0_axi_araddr(s_araddr[0]),
    .s0_axi_arlen(s_arlen[0]), .s0_axi_arid(s_arid[0]),
    .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]), .s0_axi_rlast(s_rlast[0]),
    .s0_axi_rdata(s_rdata[0]), .s0_axi_rid(s_rid[0]), .s0_axi_rresp(s_rresp[0]),
    .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]), .s1_axi_awaddr(s_awaddr[1]),
    .s1_axi_awlen(s_awlen[1]), .s1_axi_awid(s_awid[1]),
    .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]), .s1_axi_wlast(s_wlast[1]),
    .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]),
    .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]), .s1_axi_bid(s_bid[1]), .s1_axi_bresp(s_bresp[1]),
    .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s_arready[1]), .s1_axi_araddr(s_araddr[1]),
    .s1_axi_arlen(s_arlen[1]), .s1_axi_arid(s_arid[1]),
    .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]), .s1_axi_rlast(s_rlast[1]),
    .s1_axi_rdata(s_rdata[1]), .s1_axi_rid(s_rid[1]), .s1_axi_rresp(s_rresp[1]),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready), .m_axi_awaddr(m_awaddr),
    .m_axi_awlen(m_awlen), .m_axi_awid(m_awid),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_wlast(m_wlast),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_araddr(m_araddr),
    .m_axi_arlen(m_arlen), .m_axi_arid(m_arid),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .m_axi_rlast(m_rlast),
    .m_axi_rdata(m_rdata), .m_axi_rid(m_rid), .m_axi_rresp(m_rresp)
  );

  // Behavioural BRAM slave: always ready in each phase, 64-bit word memory.
  logic [63:0] mem [256];
  logic [1:0]  ws;
  logic        rs;
  logic [7:0]  widx, wl, wb, ridx, rl, rb;
  logic [3:0]  wid_r, rid_r;
  int          wlast_err = 0;

  assign m_awready = (ws == 2'd0);
  assign m_wready  = (ws == 2'd1);
  assign m_bvalid  = (ws == 2'd2);
  assign m_bid     = wid_r;
  assign m_bresp   = 2'b00;
  assign m_arready = !rs;
  assign m_rvalid  = rs;
  assign m_rdata   = mem[ridx + rb];
  assign m_rlast   = (rb == rl);
  assign m_rid     = rid_r;
  assign m_rresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ws <= 2'd0; rs <= 1'b0; wb <= 8'd0; rb <= 8'd0;
      widx <= 8'd0; wl <= 8'd0; ridx <= 8'd0; rl <= 8'd0; wid_r <= 4'd0; rid_r <= 4'd0;
    end else begin
      case (ws)
        2'd0: if (m_awvalid) begin
          widx <= m_awaddr[10:3]; wl <= m_awlen; wb <= 8'd0; wid_r <= m_awid; ws <= 2'd1;
        end
        2'd1: if (m_wvalid) begin
          for (int b = 0; b < 8; b++)
            if (m_wstrb[b]) mem[widx + wb][b*8 +: 8] <= m_wdata[b*8 +: 8];
          if (m_wlast != (wb == wl)) wlast_err <= wlast_err + 1;
          wb <= wb + 8'd1;
          if (m_wlast) ws <= 2'd2;
        end
        default: if (m_bready) ws <= 2'd0;
      endcase
      if (!rs && m_arvalid) begin
        ridx <= m_araddr[10:3]; rl <= m_arlen; rb <= 8'd0; rid_r <= m_arid; rs <= 1'b1;
      end else if (rs && m_rready) begin
        rb <= rb + 8'd1;
        if (rb == rl) rs <= 1'b0;
      end
    end
  end

  // Handshake monitor: records the index of the rising edge each handshake lands on.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         aw_q[$], b_q[$], ar_q[$], rl_q[$];
  logic [3:0] awid_q[$], arid_q[$];
  int         s0_rv_cnt = 0;

  always @(negedge clk) begin
    #2;
    if (m_awvalid && m_awready) begin aw_q.push_back(cyc + 1); awid_q.push_back(m_awid); end
    if (m_arvalid && m_arready) begin ar_q.push_back(cyc + 1); arid_q.push_back(m_arid); end
    if (m_bvalid && m_bready) b_q.push_back(cyc + 1);
    if (m_rvalid && m_rready && m_rlast) rl_q.push_back(cyc + 1);
    if (s_rvalid[0]) s0_rv_cnt++;
  end

  logic [14:0] all_vr;
  assign all_vr = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                   s_awready, s_wready, s_bvalid, s_arready, s_rvalid};

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // All master tasks are entered and left just after a falling edge.
  task automatic aw_phase(input int p, input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n;
    n = 0;
    s_awvalid[p] = 1'b1; s_awaddr[p] = addr; s_awlen[p] = len; s_awid[p] = id;
    #1;
    while (!s_awready[p] && n < LIM) begin @(negedge clk); #1; n++; end
    check("aw_handshake", n < LIM, 1);
    @(negedge clk);
    s_awvalid[p] = 1'b0;
  endtask

  task automatic w_phase(input int p, input logic [63:0] base, input logic [7:0] len, input int nb);
    int n;
    for (int i = 0; i < nb; i++) begin
      n = 0;
      s_wvalid[p] = 1'b1; s_wdata[p] = base + 64'(i); s_wlast[p] = (i == int'(len)); s_wstrb[p] = 8'hFF;
      #1;
      while (!s_wready[p] && n < LIM) begin @(negedge clk); #1; n++; end
      check("w_handshake", n < LIM, 1);
      @(negedge clk);
    end
    s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0; s_wstrb[p] = 8'h00;
  endtask

  task automatic b_phase(input int p, input logic [3:0] id);
    int n;
    n = 0;
    s_bready[p] = 1'b1;
    #1;
    while (!s_bvalid[p] && n < LIM) begin @(negedge clk); #1; n++; end
    check("b_handshake", n < LIM, 1);
    check("bid", s_bid[p], id);
    check("bresp", s_bresp[p], 0);
    @(negedge clk);
    s_bready[p] = 1'b0;
  endtask

  task automatic do_write(input int p, input logic [63:0] addr, input logic [7:0] len,
                          input logic [63:0] base, input logic [3:0] id);
    aw_phase(p, addr, len, id);
    w_phase(p, base, len, int'(len) + 1);
    b_phase(p, id);
  endtask

  task automatic ar_phase(input int p, input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n;
    n = 0;
    s_arvalid[p] = 1'b1; s_araddr[p] = addr; s_arlen[p] = len; s_arid[p] = id;
    #1;
    while (!s_arready[p] && n < LIM) begin @(negedge clk); #1; n++; end
    check("ar_handshake", n < LIM, 1);
    @(negedge clk);
    s_arvalid[p] = 1'b0;
  endtask

  task automatic r_phase(input int p, input logic [7:0] len, input logic [63:0] base,
                         input logic [3:0] id, input bit toggle);
    int n, i;
    bit tog, done;
    n = 0; i = 0; tog = 1'b1; done = 1'b0;
    while (!done && n < LIM) begin
      s_rready[p] = toggle ? tog : 1'b1;
      tog = !tog;
      #1;
      if (s_rvalid[p] && s_rready[p]) begin
        check("rdata", s_rdata[p], base + 64'(i));
        check("rlast", s_rlast[p], (i == int'(len)));
        check("rid", s_rid[p], id);
        check("rresp", s_rresp[p], 0);
        if (s_rlast[p]) done = 1'b1;
        i++;
      end
      @(negedge clk);
      n++;
    end
    s_rready[p] = 1'b0;
    check("r_beats", i, int'(len) + 1);
  endtask

  task automatic do_read(input int p, input logic [63:0] addr, input logic [7:0] len,
                         input logic [63:0] base, input logic [3:0] id, input bit toggle);
    ar_phase(p, addr, len, id);
    r_phase(p, len, base, id, toggle);
  endtask

  task automatic clear_drives();
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_awlen = '0; s_arlen = '0; s_wstrb = '0;
    s_awid = '0; s_arid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_drives();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s, base, rv0;
    rst = 1'b1;
    clear_drives();
    // Requests held during reset must not leak through.
    s_awvalid = 2'b11; s_arvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11; s_rready = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", all_vr, 0);
    @(negedge clk);
    clear_drives();
    rst = 1'b0;
    @(negedge clk);

    // Port 0 4-beat write, then read back.
    s = cyc;
    do_write(0, 64'h100, 8'd3, 64'hA0, 4'h5);
    check("wr4_aw_cycle", aw_q[$], s + 2);
    check("wr4_b_cycle", b_q[$], s + 7);
    check("mem_0x118", mem[8'd35], 64'hA3);
    do_read(0, 64'h100, 8'd3, 64'hA0, 4'h6, 1'b0);

    // Write-path ties after reset: port 0, port 1, then port 0, port 1 again.
    do_reset();
    base = awid_q.size();
    fork
      do_write(0, 64'h200, 8'd7, 64'hB0, 4'h1);
      do_write(1, 64'h300, 8'd0, 64'hC0, 4'h2);
    join
    fork
      do_write(0, 64'h308, 8'd0, 64'hC1, 4'h1);
      do_write(1, 64'h310, 8'd0, 64'hC2, 4'h2);
    join
    check("aw_grant_count", awid_q.size() - base, 4);
    if (awid_q.size() - base == 4) begin
      check("aw_grant_0", awid_q[base],     4'h1);
      check("aw_grant_1", awid_q[base + 1], 4'h2);
      check("aw_grant_2", awid_q[base + 2], 4'h1);
      check("aw_grant_3", awid_q[base + 3], 4'h2);
    end

    // Read-path ties follow the same alternation.
    base = arid_q.size();
    fork
      do_read(0, 64'h200, 8'd0, 64'hB0, 4'h1, 1'b0);
      do_read(1, 64'h300, 8'd0, 64'hC0, 4'h2, 1'b0);
    join
    fork
      do_read(0, 64'h308, 8'd0, 64'hC1, 4'h1, 1'b0);
      do_read(1, 64'h310, 8'd0, 64'hC2, 4'h2, 1'b0);
    join
    check("ar_grant_count", arid_q.size() - base, 4);
    if (arid_q.size() - base == 4) begin
      check("ar_grant_0", arid_q[base],     4'h1);
      check("ar_grant_1", arid_q[base + 1], 4'h2);
      check("ar_grant_2", arid_q[base + 2], 4'h1);
      check("ar_grant_3", arid_q[base + 3], 4'h2);
    end

    // Concurrent write (port 0) and 8-beat read (port 1).
    s = cyc;
    fork
      do_write(0, 64'h400, 8'd7, 64'hD0, 4'h3);
      do_read(1, 64'h200, 8'd7, 64'hB0, 4'h4, 1'b0);
    join
    check("conc_aw_cycle", aw_q[$], s + 2);
    check("conc_ar_cycle", ar_q[$], s + 2);
    check("conc_rlast_cycle", rl_q[$], s + 10);
    check("conc_b_cycle", b_q[$], s + 11);
    check("mem_0x438", mem[8'd135], 64'hD7);

    // Back-to-back single-beat bursts from one port.
    do_write(0, 64'h500, 8'd0, 64'hE0, 4'h7);
    do_write(0, 64'h508, 8'd0, 64'hE1, 4'h7);
    check("sb_aw_period", aw_q[$] - aw_q[$-1], 4);
    check("sb_b_to_aw", aw_q[$] - b_q[$-1], 2);
    do_read(0, 64'h500, 8'd0, 64'hE0, 4'h8, 1'b0);
    do_read(0, 64'h508, 8'd0, 64'hE1, 4'h8, 1'b0);
    check("sb_ar_period", ar_q[$] - ar_q[$-1], 3);
    check("sb_r_to_ar", ar_q[$] - rl_q[$-1], 2);
    check("wlast_position", wlast_err, 0);

    // Port 1 read under rready backpressure; port 0 must see no rvalid.
    rv0 = s0_rv_cnt;
    do_read(1, 64'h200, 8'd7, 64'hB0, 4'h9, 1'b1);
    check("s0_rvalid_quiet", s0_rv_cnt - rv0, 0);

    // Reset during the third beat of a 4-beat write.
    aw_phase(0, 64'h700, 8'd3, 4'h3);
    w_phase(0, 64'hF0, 8'd3, 2);
    s_wvalid[0] = 1'b1; s_wdata[0] = 64'hF2; s_wstrb[0] = 8'hFF;
    #1;
    check("pre_rst_wready", s_wready[0], 1);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", all_vr, 0);
    @(negedge clk);
    #1;
    check("rst_outputs", all_vr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_idle_wready", s_wready[0], 0);
    @(negedge clk);
    clear_drives();
    do_write(1, 64'h708, 8'd1, 64'h90, 4'hA);
    do_read(1, 64'h708, 8'd1, 64'h90, 4'hB, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
